// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue path.
//  - XLEN/OP_W defaults used by the issue controller
//  - FPU opcode encodings seen on in_FPU_Op
//  - issue-controller FSM state type
package fpu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OP_W_DEF = 5;

  localparam logic [4:0] FPU_OP_FADD    = 5'd0;
  localparam logic [4:0] FPU_OP_FSUB    = 5'd1;
  localparam logic [4:0] FPU_OP_FMUL    = 5'd2;
  localparam logic [4:0] FPU_OP_FDIV    = 5'd3;
  localparam logic [4:0] FPU_OP_FSQRT   = 5'd4;
  localparam logic [4:0] FPU_OP_FCVT_SW = 5'd5;
  localparam logic [4:0] FPU_OP_FCVT_WS = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fpu_watchdog.sv
// Watchdog for a hung FPU.
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : zero the counter (issue cycle)
//  en         : count one waiting cycle
//  at_limit   : counter has reached TIMEOUT_CYC-1; an enabled cycle now is the last allowed
//  err        : sticky timeout flag, cleared only by reset
module fpu_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit,
  output logic err
);

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
      if (en && at_limit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// EX-stage initiator for the FPU core handshake.
// Latches one FPU instruction, pulses fpu_start, freezes the pipeline while the
// FPU is busy, then returns a single write-back beat. Flush and watchdog expiry
// both mark the in-flight result as killed so the beat is suppressed.
//  in_Clk, in_Rst_N              : clock, asynchronous active-low reset
//  ex_valid/ex_fpu_op/ex_rs1/ex_rs2/ex_int_in/ex_rd : instruction from EX
//  flush                         : kill the in-flight instruction
//  fpu_start/fpu_op/fpu_rs1/fpu_rs2/fpu_int : request to FPU
//  fpu_data/fpu_stall            : response from FPU
//  stall_o                       : freeze upstream pipeline
//  wb_valid/wb_data/wb_rd/wb_zero: write-back beat
//  err_timeout                   : sticky watchdog flag
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic            in_Clk,
  input  logic            in_Rst_N,
  input  logic            ex_valid,
  input  logic [OP_W-1:0] ex_fpu_op,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_int_in,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            fpu_start,
  output logic [OP_W-1:0] fpu_op,
  output logic [XLEN-1:0] fpu_rs1,
  output logic [XLEN-1:0] fpu_rs2,
  output logic [XLEN-1:0] fpu_int,
  input  logic [XLEN-1:0] fpu_data,
  input  logic            fpu_stall,
  output logic            stall_o,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_zero,
  output logic            err_timeout
);

  fsm_state_t state_q, state_d;
  logic       kill_q, kill_d;
  logic [4:0] rd_q;
  logic       accept, capture;
  logic       wd_clr, wd_en, wd_at_limit;

  fpu_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk      (in_Clk),
    .rst_n    (in_Rst_N),
    .clr      (wd_clr),
    .en       (wd_en),
    .at_limit (wd_at_limit),
    .err      (err_timeout)
  );

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      rd_q    <= '0;
      fpu_op  <= '0;
      fpu_rs1 <= '0;
      fpu_rs2 <= '0;
      fpu_int <= '0;
      wb_data <= '0;
      wb_rd   <= '0;
      wb_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (accept) begin
        fpu_op  <= ex_fpu_op;
        fpu_rs1 <= ex_rs1;
        fpu_rs2 <= ex_rs2;
        fpu_int <= ex_int_in;
        rd_q    <= ex_rd;
      end
      // wb_zero is registered alongside wb_data so it tracks the captured value
      // while still reading 0 out of reset.
      if (capture) begin
        wb_data <= fpu_data;
        wb_rd   <= rd_q;
        wb_zero <= (fpu_data == '0);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    accept    = 1'b0;
    capture   = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    fpu_start = 1'b0;
    stall_o   = 1'b0;
    wb_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid && !flush) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fpu_start = 1'b1;
        stall_o   = 1'b1;
        wd_clr    = 1'b1;
        if (flush) kill_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (flush) kill_d = 1'b1;
        // Killed results still drain through the capture path; only the
        // write-back strobe is withheld. Only busy cycles age the watchdog.
        if (!fpu_stall) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_en = 1'b1;
          if (wd_at_limit) begin
            kill_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        wb_valid = !kill_q && !flush;
        kill_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int unsigned T = 64;

  logic        in_Clk = 1'b0;
  logic        in_Rst_N;
  logic        ex_valid;
  logic [4:0]  ex_fpu_op;
  logic [31:0] ex_rs1, ex_rs2, ex_int_in;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_int;
  logic [31:0] fpu_data;
  logic        fpu_stall;
  logic        stall_o, wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_zero, err_timeout;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic        err_exp  = 1'b0;

  fpu_issue_ctrl #(
    .XLEN        (32),
    .OP_W        (5),
    .TIMEOUT_CYC (T),
    .CNT_W       (7)
  ) dut (
    .in_Clk      (in_Clk),
    .in_Rst_N    (in_Rst_N),
    .ex_valid    (ex_valid),
    .ex_fpu_op   (ex_fpu_op),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_int_in   (ex_int_in),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .fpu_rs1     (fpu_rs1),
    .fpu_rs2     (fpu_rs2),
    .fpu_int     (fpu_int),
    .fpu_data    (fpu_data),
    .fpu_stall   (fpu_stall),
    .stall_o     (stall_o),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_zero     (wb_zero),
    .err_timeout (err_timeout)
  );

  always #5 in_Clk = ~in_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".fpu_start"}, 32'(fpu_start), 32'd0);
    chk({tag, ".stall_o"},   32'(stall_o),   32'd0);
    chk({tag, ".wb_valid"},  32'(wb_valid),  32'd0);
    chk({tag, ".fpu_op"},    32'(fpu_op),    32'd0);
    chk({tag, ".fpu_rs1"},   fpu_rs1,        32'd0);
    chk({tag, ".fpu_rs2"},   fpu_rs2,        32'd0);
    chk({tag, ".fpu_int"},   fpu_int,        32'd0);
    chk({tag, ".wb_data"},   wb_data,        32'd0);
    chk({tag, ".wb_rd"},     32'(wb_rd),     32'd0);
    chk({tag, ".wb_zero"},   32'(wb_zero),   32'd0);
    chk({tag, ".err"},       32'(err_timeout), 32'd0);
  endtask

  // One transaction against a behavioural FPU that stays busy for `busy`
  // cycles after it sees fpu_start. flush_at = k raises flush during the k-th
  // cycle after the start cycle (0 = never).
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] iv, input logic [31:0] res,
                        input logic [4:0] rd, input int unsigned busy, input int unsigned flush_at);
    int unsigned start_cnt = 0, start_cyc = 999, stall_cnt = 0, wb_cnt = 0, wb_cyc = 999;
    int unsigned k = 0, ncyc;
    logic [31:0] wbd = '0;
    logic [4:0]  wbr = '0;
    logic        wbz = 1'b0;
    bit          started = 0, timed_out, exp_wb;

    timed_out = (busy >= T);
    exp_wb    = !timed_out && (flush_at == 0);
    ncyc      = (timed_out ? T : busy) + 8;
    fpu_data  = res;
    for (int unsigned t = 0; t < ncyc; t++) begin
      @(posedge in_Clk); #1;
      if (t == 0) begin
        ex_valid = 1'b1; ex_fpu_op = op; ex_rs1 = a; ex_rs2 = b; ex_int_in = iv; ex_rd = rd;
      end else begin
        ex_valid = 1'b0; ex_fpu_op = ~op; ex_rs1 = ~a; ex_rs2 = ~b; ex_int_in = ~iv; ex_rd = ~rd;
      end
      if (started) k++;
      fpu_stall = started && (k <= busy);
      flush     = started && (flush_at != 0) && (k == flush_at);
      @(negedge in_Clk);
      if (fpu_start) begin
        start_cnt++;
        if (start_cnt == 1) begin
          start_cyc = t;
          started   = 1;
          chk({tag, ".op"},  32'(fpu_op), 32'(op));
          chk({tag, ".rs1"}, fpu_rs1, a);
          chk({tag, ".rs2"}, fpu_rs2, b);
          chk({tag, ".int"}, fpu_int, iv);
        end
      end
      if (stall_o) stall_cnt++;
      if (wb_valid) begin
        wb_cnt++; wb_cyc = t; wbd = wb_data; wbr = wb_rd; wbz = wb_zero;
        chk({tag, ".op_hold"}, 32'(fpu_op), 32'(op));
      end
    end
    fpu_stall = 1'b0;
    flush     = 1'b0;
    err_exp   = err_exp | timed_out;

    chk({tag, ".start_cnt"}, start_cnt, 32'd1);
    chk({tag, ".start_cyc"}, start_cyc, 32'd1);
    chk({tag, ".stall_cyc"}, stall_cnt, timed_out ? T + 1 : busy + 2);
    chk({tag, ".wb_cnt"},    wb_cnt, exp_wb ? 32'd1 : 32'd0);
    if (exp_wb) begin
      chk({tag, ".wb_lat"},  wb_cyc, busy + 3);
      chk({tag, ".wb_data"}, wbd, res);
      chk({tag, ".wb_rd"},   32'(wbr), 32'(rd));
      chk({tag, ".wb_zero"}, 32'(wbz), (res == 32'd0) ? 32'd1 : 32'd0);
    end
    chk({tag, ".err"},      32'(err_timeout), 32'(err_exp));
    chk({tag, ".idle_stl"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    int unsigned starts, wbs, first_s, second_s, busy, fl, sel;
    logic [31:0] res;

    in_Rst_N = 1'b0; ex_valid = 1'b0; ex_fpu_op = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_int_in = '0; ex_rd = '0; flush = 1'b0; fpu_data = '0; fpu_stall = 1'b0;
    repeat (2) @(negedge in_Clk);
    chk_all_zero("reset");
    in_Rst_N = 1'b1;
    @(negedge in_Clk);

    run_op("fadd",   FPU_OP_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4040_0000, 5'd1, 4, 0);
    run_op("single", FPU_OP_FMUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0BAD_F00D, 5'd5, 0, 0);
    run_op("zero",   FPU_OP_FSUB, 32'h4120_0000, 32'h4120_0000, 32'h0, 32'h0000_0000, 5'd7, 2, 0);
    run_op("negz",   FPU_OP_FSUB, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h8000_0000, 5'd8, 1, 0);
    run_op("flushw", FPU_OP_FDIV, 32'h4000_0000, 32'h3F00_0000, 32'h0, 32'h4080_0000, 5'd9, 5, 2);
    run_op("flushd", FPU_OP_FADD, 32'h1,         32'h2,         32'h0, 32'h0000_00AA, 5'd10, 1, 3);
    run_op("tmo",    FPU_OP_FSQRT, 32'h4080_0000, 32'h0,        32'h0, 32'h4000_0000, 5'd11, 100, 0);
    run_op("post",   FPU_OP_FCVT_SW, 32'h0,       32'h0,        32'd7, 32'h40E0_0000, 5'd12, 2, 0);

    for (int unsigned i = 0; i < 8; i++) begin
      busy = $urandom_range(0, 6);
      sel  = $urandom_range(0, 3);
      res  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 : $urandom;
      fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, busy + 2) : 0;
      run_op("rand", 5'($urandom_range(0, 6)), $urandom, $urandom, $urandom, res,
             5'($urandom_range(0, 31)), busy, fl);
    end

    // flush in IDLE blocks acceptance
    starts = 0;
    for (int unsigned t = 0; t < 4; t++) begin
      @(posedge in_Clk); #1;
      ex_valid = 1'b1; flush = 1'b1;
      @(negedge in_Clk);
      if (fpu_start || stall_o) starts++;
    end
    ex_valid = 1'b0; flush = 1'b0;
    chk("idle_flush.busy", starts, 32'd0);

    // reset in the middle of WAIT
    fpu_stall = 1'b1;
    @(posedge in_Clk); #1;
    ex_valid = 1'b1; ex_fpu_op = FPU_OP_FMUL; ex_rs1 = 32'hDEAD_BEEF; ex_rs2 = 32'h1; ex_rd = 5'd3;
    @(posedge in_Clk); #1;
    ex_valid = 1'b0;
    repeat (3) @(posedge in_Clk);
    #2;
    chk("midwait.stall_o", 32'(stall_o), 32'd1);
    in_Rst_N = 1'b0;
    err_exp  = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge in_Clk);
    in_Rst_N  = 1'b1;
    fpu_stall = 1'b0;
    starts = 0; wbs = 0;
    for (int unsigned t = 0; t < 6; t++) begin
      @(negedge in_Clk);
      if (fpu_start) starts++;
      if (wb_valid) wbs++;
    end
    chk("postrst.start", starts, 32'd0);
    chk("postrst.wb",    wbs,    32'd0);

    // ex_valid held high: acceptance only in the cycle after DONE
    starts = 0; wbs = 0; first_s = 999; second_s = 999;
    fpu_data = 32'h3F80_0000;
    for (int unsigned t = 0; t < 12; t++) begin
      @(posedge in_Clk); #1;
      ex_valid = 1'b1; ex_rd = 5'(t);
      @(negedge in_Clk);
      if (fpu_start) begin
        starts++;
        if (starts == 1) first_s = t;
        if (starts == 2) second_s = t;
      end
      if (wb_valid) wbs++;
    end
    ex_valid = 1'b0;
    chk("b2b.starts",   starts,   32'd3);
    chk("b2b.first",    first_s,  32'd1);
    chk("b2b.second",   second_s, 32'd5);
    chk("b2b.wb",       wbs,      32'd3);
    chk("b2b.err",      32'(err_timeout), 32'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
